bsg_fifo_1r1w_small_counted: RTL and testbench
==============================================

// Module: bsg_fifo_1r1w_small_counted
// PURPOSE
//  Small 1-read/1-write FIFO with async-read register storage and any depth els_p >= 2 (not just powers of two).
//  Adds an occupancy count, a programmable almost-full flag and an optional zero-latency empty bypass.
//  Used for link and endpoint buffering where credit logic needs count_o and almost_full_o.
// PARAMETERS
//  width_p            (none)      data width in bits, >= 1
//  els_p              (none)      depth in entries, >= 2, any integer
//  afull_thresh_p     els_p-1     almost_full_o asserts when count >= this value; legal range 1..els_p
//  ready_THEN_valid_p 0           0: valid-and-ready input; 1: ready-then-valid input
// PORTS
//  clk_i          in   1                      clock; the only clock
//  reset_i        in   1                      asynchronous, active-high reset
//  v_i            in   1                      input data valid
//  ready_o        out  1                      FIFO can accept an entry this cycle
//  data_i         in   width_p                input data
//  v_o            out  1                      head entry valid
//  data_o         out  width_p                head entry data (async read)
//  yumi_i         in   1                      consumer takes the head this cycle; legal only when v_o=1
//  count_o        out  $clog2(els_p+1)        number of stored entries
//  almost_full_o  out  1                      count_o >= afull_thresh_p
// BEHAVIOUR
//  - Reset (async, active-high): wptr=0, rptr=0, count=0. While reset_i=1, v_o=0, ready_o=0, count_o=0 and almost_full_o=0.
//    The first cycle after reset deasserts has ready_o=1. Storage is not reset.
//  - enq = v_i & ready_o when ready_THEN_valid_p=0. enq = v_i when ready_THEN_valid_p=1; v_i while ready_o=0 is then an
//    assertion error.
//  - deq = yumi_i. yumi_i while v_o=0 is an assertion error.
//  - ready_o = (count != els_p), taken from registered state only. There is no combinational path from yumi_i to ready_o.
//    When full, the same-cycle enq is refused even if deq=1.
//  - v_o = (count != 0); data_o = mem[rptr].
//  - Write-to-read latency is 1 cycle: data enqueued in cycle N is visible at v_o/data_o in cycle N+1.
//  - Pointer wrap: ptr_next = (ptr == els_p-1) ? 0 : ptr+1. This wraps correctly for non-power-of-two depths.
//  - count_next = count + enq - deq. Simultaneous enq and deq leaves count unchanged and advances both pointers.
//  - Empty with enq and deq in the same cycle is impossible without bypass, because v_o=0.
//  - almost_full_o is registered-state based, so it is glitch-free and has no dependence on v_i or yumi_i.
//  - Reset asserted mid-operation drops all entries immediately.
//  - Assertions (non-synthesis): els_p >= 2; afull_thresh_p in 1..els_p; no overflow; no underflow.
// CONFIGURATION
//  Macro BSG_FIFO_SMALL_BYPASS_EN.
//  - Defined: when count=0, v_o = v_i & ready_o and data_o = data_i (combinational bypass).
//    If yumi_i=1 in that cycle, the entry is consumed and never written: pointers and count are unchanged.
//    If yumi_i=0, the entry is written as usual.
//    count_o and almost_full_o ignore the in-flight bypass entry.
//  - Undefined: no v_i-to-v_o or data_i-to-data_o combinational path, and latency is exactly 1.
// STRUCTURE
//  - Shared package bsg_fifo_small_pkg holds:
//    - function bsg_fifo_small_ptr_inc(ptr, els) for the wrap rule above;
//    - localparam helpers for pointer width ($clog2(els_p) with a minimum of 1) and count width.
//  - One sub-module, bsg_fifo_small_tracker: wptr, rptr and count registers plus full/empty.
//    Inputs enq/deq; outputs wptr, rptr, count. The top module holds the register array, handshake logic and bypass mux.
// TESTING
//  1. els_p=3, width_p=8: enq 0x11,0x22,0x33 -> count_o 1,2,3; ready_o=0 after the third;
//     data_o=0x11 one cycle after the first enq.
//  2. els_p=3 full, v_i=1 with data 0x44 and yumi_i=1 -> 0x11 leaves, 0x44 refused, count_o=2, ready_o=1 next cycle.
//  3. els_p=5, stream 20 entries at full rate with random yumi_i -> output order intact,
//     pointers wrap 4->0, count_o never exceeds 5.
//  4. els_p=4, afull_thresh_p=3: fill to 2 -> almost_full_o=0; fill to 3 -> almost_full_o=1;
//     deq one -> almost_full_o=0.
//  5. Reset asserted with 2 entries stored -> v_o=0, ready_o=0 and count_o=0 immediately;
//     after release, ready_o=1 and no stale data_o is reported valid.
//  6. With BSG_FIFO_SMALL_BYPASS_EN, empty, v_i=1 data 0xA5, yumi_i=1 -> v_o=1 and data_o=0xA5 in the same cycle;
//     count_o stays 0 the next cycle.

Source files
------------

// File: rtl/bsg_fifo_small_pkg.sv
// Shared helpers for the small counted FIFO: pointer/count widths and the
// modulo-els pointer increment used for non-power-of-two depths.
package bsg_fifo_small_pkg;

   // Pointer width, never narrower than one bit.
   function automatic int bsg_fifo_small_ptr_w(input int els);
      int w;
      w = $clog2(els);
      return (w < 1) ? 1 : w;
   endfunction

   // Count width: must hold values 0..els inclusive.
   function automatic int bsg_fifo_small_cnt_w(input int els);
      return $clog2(els + 1);
   endfunction

   // Wraps at els-1 rather than at a power of two.
   function automatic int bsg_fifo_small_ptr_inc(input int ptr, input int els);
      return (ptr == els - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/bsg_fifo_small_tracker.sv
// Write/read pointer and occupancy tracker for bsg_fifo_1r1w_small_counted.
// Callers must never enqueue when full or dequeue when empty.
module bsg_fifo_small_tracker
   import bsg_fifo_small_pkg::*;
#(
   parameter  int els_p    = 2,
   localparam int ptr_w_lp = bsg_fifo_small_ptr_w(els_p),
   localparam int cnt_w_lp = bsg_fifo_small_cnt_w(els_p)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                enq_i,
   input  logic                deq_i,
   output logic [ptr_w_lp-1:0] wptr_o,
   output logic [ptr_w_lp-1:0] rptr_o,
   output logic [cnt_w_lp-1:0] count_o,
   output logic                full_o,
   output logic                empty_o
);

   logic [ptr_w_lp-1:0] wptr_q, wptr_d;
   logic [ptr_w_lp-1:0] rptr_q, rptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq_i) wptr_d = ptr_w_lp'(bsg_fifo_small_ptr_inc(int'(wptr_q), els_p));
      if (deq_i) rptr_d = ptr_w_lp'(bsg_fifo_small_ptr_inc(int'(rptr_q), els_p));
      // Simultaneous enq/deq leaves the count untouched.
      if (enq_i && !deq_i) count_d = count_q + cnt_w_lp'(1);
      else if (!enq_i && deq_i) count_d = count_q - cnt_w_lp'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign wptr_o  = wptr_q;
   assign rptr_o  = rptr_q;
   assign count_o = count_q;
   assign full_o  = (count_q == cnt_w_lp'(els_p));
   assign empty_o = (count_q == '0);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(enq_i && !deq_i && full_o))
      else $error("tracker overflow");

   a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(deq_i && empty_o))
      else $error("tracker underflow");

endmodule

// File: rtl/bsg_fifo_1r1w_small_counted.sv
// Small 1R1W FIFO, any depth >= 2, with occupancy count and almost-full flag.
// Optional zero-latency empty bypass when BSG_FIFO_SMALL_BYPASS_EN is defined.
module bsg_fifo_1r1w_small_counted
   import bsg_fifo_small_pkg::*;
#(
   parameter int width_p            = 8,
   parameter int els_p              = 2,
   parameter int afull_thresh_p     = els_p - 1,
   parameter int ready_THEN_valid_p = 0
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     v_i,
   output logic                                     ready_o,
   input  logic [width_p-1:0]                       data_i,
   output logic                                     v_o,
   output logic [width_p-1:0]                       data_o,
   input  logic                                     yumi_i,
   output logic [bsg_fifo_small_cnt_w(els_p)-1:0]   count_o,
   output logic                                     almost_full_o
);

   localparam int ptr_w_lp = bsg_fifo_small_ptr_w(els_p);
   localparam int cnt_w_lp = bsg_fifo_small_cnt_w(els_p);

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] wptr, rptr;
   logic [cnt_w_lp-1:0] count;
   logic                full, empty;
   logic                enq, bypass_take;
   logic                trk_enq, trk_deq;

   // Reset gates ready so nothing is accepted while the FIFO is held in reset.
   assign ready_o = ~reset_i & ~full;

   always_comb begin
      enq = v_i & ready_o;
      if (ready_THEN_valid_p != 0) enq = v_i;
   end

`ifdef BSG_FIFO_SMALL_BYPASS_EN
   // An entry arriving at an empty FIFO and taken the same cycle is never stored.
   assign bypass_take = empty & enq & yumi_i;
   assign v_o         = ~empty | (v_i & ready_o);
   assign data_o      = empty ? data_i : mem_q[rptr];
`else
   assign bypass_take = 1'b0;
   assign v_o         = ~empty;
   assign data_o      = mem_q[rptr];
`endif

   assign trk_enq = enq & ~bypass_take;
   assign trk_deq = yumi_i & ~bypass_take;

   bsg_fifo_small_tracker #(
      .els_p (els_p)
   ) u_tracker (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (trk_enq),
      .deq_i   (trk_deq),
      .wptr_o  (wptr),
      .rptr_o  (rptr),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk_i) begin
      if (trk_enq) mem_q[wptr] <= data_i;
   end

   assign count_o       = count;
   assign almost_full_o = (count >= cnt_w_lp'(afull_thresh_p));

   a_els_legal: assert property (@(posedge clk_i) els_p >= 2)
      else $error("els_p must be >= 2");

   a_thresh_legal: assert property (@(posedge clk_i)
      (afull_thresh_p >= 1) && (afull_thresh_p <= els_p))
      else $error("afull_thresh_p out of range");

   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !((ready_THEN_valid_p != 0) && v_i && !ready_o))
      else $error("v_i while ready_o=0");

   a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o))
      else $error("yumi_i while v_o=0");

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_counted.sv
// Bench for bsg_fifo_1r1w_small_counted: three depths (3, 5, 4), table vectors,
// hand-written afull/reset sequences and a randomized queue-model run.
module tb_bsg_fifo_1r1w_small_counted;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // els_p=3
  logic       a_v, a_y, a_vo, a_ro, a_af;
  logic [7:0] a_d, a_do;
  logic [1:0] a_cnt;
  // els_p=5
  logic       b_v, b_y, b_vo, b_ro, b_af;
  logic [7:0] b_d, b_do;
  logic [2:0] b_cnt;
  // els_p=4, afull_thresh_p=3
  logic       c_v, c_y, c_vo, c_ro, c_af;
  logic [7:0] c_d, c_do;
  logic [2:0] c_cnt;

  bsg_fifo_1r1w_small_counted #(.width_p(8), .els_p(3)) u_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v), .ready_o(a_ro), .data_i(a_d),
    .v_o(a_vo), .data_o(a_do), .yumi_i(a_y), .count_o(a_cnt), .almost_full_o(a_af));

  bsg_fifo_1r1w_small_counted #(.width_p(8), .els_p(5)) u_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v), .ready_o(b_ro), .data_i(b_d),
    .v_o(b_vo), .data_o(b_do), .yumi_i(b_y), .count_o(b_cnt), .almost_full_o(b_af));

  bsg_fifo_1r1w_small_counted #(.width_p(8), .els_p(4), .afull_thresh_p(3)) u_c (
    .clk_i(clk), .reset_i(rst), .v_i(c_v), .ready_o(c_ro), .data_i(c_d),
    .v_o(c_vo), .data_o(c_do), .yumi_i(c_y), .count_o(c_cnt), .almost_full_o(c_af));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       y;
    logic       ev;
    logic [7:0] ed;
    logic       er;
    int         ec;
    logic       eaf;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];

  initial begin
    int  size;
    int  max_cnt;
    logic exp_v, bypass_vis, enq, deq;
    logic [7:0] exp_d;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    {a_v, a_y, b_v, b_y, c_v, c_y} = '0;
    a_d = '0; b_d = '0; c_d = '0;

    // Inputs applied before the edge; expected outputs seen before that edge.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0};
`ifdef BSG_FIFO_SMALL_BYPASS_EN
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 0, 1'b0};
`endif
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1, 2, 1'b1};
    vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h11, 1'b0, 3, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 2, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 2, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0};

    repeat (2) tick();
    check("rst_a_v_o", 32'(a_vo), 32'd0);
    check("rst_a_ready_o", 32'(a_ro), 32'd0);
    check("rst_a_count_o", 32'(a_cnt), 32'd0);
    check("rst_a_afull_o", 32'(a_af), 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      a_v = vecs[i].v;
      a_d = vecs[i].d;
      a_y = vecs[i].y;
      #1;
      check($sformatf("vec%0d_v_o", i), 32'(a_vo), 32'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("vec%0d_data_o", i), 32'(a_do), 32'(vecs[i].ed));
      check($sformatf("vec%0d_ready_o", i), 32'(a_ro), 32'(vecs[i].er));
      check($sformatf("vec%0d_count_o", i), 32'(a_cnt), 32'(vecs[i].ec));
      check($sformatf("vec%0d_afull_o", i), 32'(a_af), 32'(vecs[i].eaf));
      tick();
    end
    a_v = 1'b0; a_y = 1'b0;

`ifdef BSG_FIFO_SMALL_BYPASS_EN
    a_v = 1'b1; a_d = 8'hA5; a_y = 1'b1;
    #1;
    check("bypass_v_o", 32'(a_vo), 32'd1);
    check("bypass_data_o", 32'(a_do), 32'hA5);
    tick();
    a_v = 1'b0; a_y = 1'b0;
    #1;
    check("bypass_count_after", 32'(a_cnt), 32'd0);
    check("bypass_v_o_after", 32'(a_vo), 32'd0);
`endif

    // Almost-full threshold at 3 on the depth-4 instance.
    c_v = 1'b1; c_d = 8'h51; tick();
    c_d = 8'h52; tick();
    c_v = 1'b0; #1;
    check("c_count_2", 32'(c_cnt), 32'd2);
    check("c_afull_at_2", 32'(c_af), 32'd0);
    check("c_head_data", 32'(c_do), 32'h51);
    c_v = 1'b1; c_d = 8'h53; tick();
    c_v = 1'b0; #1;
    check("c_count_3", 32'(c_cnt), 32'd3);
    check("c_afull_at_3", 32'(c_af), 32'd1);
    c_y = 1'b1; tick();
    c_y = 1'b0; #1;
    check("c_count_after_deq", 32'(c_cnt), 32'd2);
    check("c_afull_after_deq", 32'(c_af), 32'd0);
    check("c_head_after_deq", 32'(c_do), 32'h52);

    // Reset with two entries held: everything drops at once.
    rst = 1'b1;
    #1;
    check("midrst_v_o", 32'(c_vo), 32'd0);
    check("midrst_ready_o", 32'(c_ro), 32'd0);
    check("midrst_count_o", 32'(c_cnt), 32'd0);
    check("midrst_afull_o", 32'(c_af), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst_ready_o", 32'(c_ro), 32'd1);
    check("postrst_v_o", 32'(c_vo), 32'd0);
    check("postrst_count_o", 32'(c_cnt), 32'd0);
    tick();
    check("postrst_v_o_later", 32'(c_vo), 32'd0);

    // Random streaming on depth 5 against a queue model.
    max_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      size = exp_q.size();
      b_v = ($urandom_range(0, 3) != 0);
      b_d = 8'($urandom);
      bypass_vis = 1'b0;
`ifdef BSG_FIFO_SMALL_BYPASS_EN
      bypass_vis = (size == 0) && b_v;
`endif
      exp_v = (size != 0) || bypass_vis;
      exp_d = (size != 0) ? exp_q[0] : b_d;
      b_y = exp_v && ($urandom_range(0, 1) == 1);
      #1;
      check("rand_v_o", 32'(b_vo), 32'(exp_v));
      if (exp_v) check("rand_data_o", 32'(b_do), 32'(exp_d));
      check("rand_count_o", 32'(b_cnt), 32'(size));
      check("rand_ready_o", 32'(b_ro), 32'(size != 5));
      check("rand_afull_o", 32'(b_af), 32'(size >= 4));
      if (int'(b_cnt) > max_cnt) max_cnt = int'(b_cnt);
      enq = b_v && (size != 5);
      deq = b_y;
      tick();
      if (!(bypass_vis && b_y)) begin
        if (deq) void'(exp_q.pop_front());
        if (enq) exp_q.push_back(b_d);
      end
    end
    b_v = 1'b0; b_y = 1'b0;
    check("rand_max_count_le_5", 32'(max_cnt <= 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
